dec_onehot_seq: RTL
===================

// Module: dec_onehot_seq
//
// PURPOSE
//   Parametrised registered AW-to-2**AW one-hot decoder with enable and two modes.
//   DECODE: Y follows onehot(A) with 1-cycle latency.
//   SCAN: walks a single active output across all 2**AW lines, holding each for SCAN_DWELL cycles.
//   Drives row/column select and enable strobes in the layout-generated datapath blocks.
//   Replaces fixed-width combinational decoders wherever registered, glitch-free selects are needed.
//
// PARAMETERS
//   AW          2   address width; output width NO = 2**AW (AW range 1..6)
//   SCAN_DWELL  4   cycles each output stays high in SCAN mode (>=1)
//
// PORTS
//   CLK   in   1        clock, all state updates on rising edge
//   RST   in   1        reset: synchronous, active-high
//   EN    in   1        block enable; 0 forces all outputs low
//   MODE  in   1        0 = DECODE, 1 = SCAN
//   A     in   AW       decode address (DECODE) / scan start index (SCAN entry)
//   Y     out  2**AW    registered one-hot select, at most one bit high
//   BUSY  out  1        high while in SCAN state
//   WRAP  out  1        1-cycle pulse when scan pointer wraps 2**AW-1 -> 0
//
// BEHAVIOUR
//   Reset
//   - RST=1 at an edge: Y=0, BUSY=0, WRAP=0, state=IDLE, ptr=0, dwell=0.
//   - RST has priority over every other input.
//   State machine and outputs
//   - States: IDLE, DECODE, SCAN. All outputs are registered; no combinational input->output path.
//   - IDLE:   EN=0 -> stay, Y=0.  EN=1,MODE=0 -> DECODE.  EN=1,MODE=1 -> SCAN.
//   - DECODE: each cycle Y <= onehot(A); latency 1 cycle from A change to Y.
//   - SCAN entry (from IDLE or DECODE): ptr <= A, dwell <= 0, Y <= onehot(A), BUSY <= 1.
//   - SCAN steady state:
//     - dwell counts 0..SCAN_DWELL-1.
//     - At dwell=SCAN_DWELL-1: ptr <= ptr+1 mod 2**AW, dwell <= 0, and Y moves to the new ptr on the same edge.
//     - SCAN_DWELL=1 advances every cycle.
//     - A is ignored while in SCAN.
//   - WRAP: asserted for exactly one cycle, coincident with the first cycle Y[0]=1 after the ptr=2**AW-1 -> 0 step.
//     - Not asserted on SCAN entry, even when A=0.
//   - Mode change while EN=1 takes effect on the next edge.
//     - SCAN -> DECODE: Y <= onehot(A), BUSY <= 0.
//     - DECODE -> SCAN: restarts from the current A.
//   - EN deassert in any state: next edge Y=0, BUSY=0, WRAP=0, state=IDLE, ptr=0, dwell=0.
//     - Re-enabling in SCAN restarts from A; no resume.
//   - Y is never multi-hot, including on the cycle of a mode or EN transition.
//   - Counter width: clog2(SCAN_DWELL), minimum 1 bit. ptr width: AW.
//
// TESTING
//   1. RST=1 mid-scan with Y=0100 -> next cycle Y=0000, BUSY=0, WRAP=0; after release with EN=0, Y stays 0.
//   2. DECODE, AW=2: A=0,1,2,3 on consecutive cycles -> Y=0001,0010,0100,1000, each one cycle later.
//   3. SCAN, AW=2, SCAN_DWELL=4, A=2 -> Y=0100 x4, 1000 x4, 0001 x4 with WRAP=1 on first 0001 cycle only, BUSY=1 throughout.
//   4. SCAN with SCAN_DWELL=1, A=0 -> Y walks 0001,0010,0100,1000,0001 on successive cycles; WRAP only on the 5th.
//   5. SCAN at Y=0010, drop EN for 1 cycle, re-raise with A=3 -> Y=0000 then 1000, dwell restarted.
//   6. SCAN -> DECODE switch with A=1 -> next cycle Y=0010, BUSY=0; every cycle checked with $onehot0(Y).

Source files
------------

// File: rtl/dec_onehot_seq.sv
// Registered AW-to-2**AW one-hot decoder: DECODE follows A one cycle later,
// SCAN walks a single select across all lines, SCAN_DWELL cycles per line.
module dec_onehot_seq #(
   parameter int AW         = 2,
   parameter int SCAN_DWELL = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_mode,
   input  logic [AW-1:0]     i_a,
   output logic [2**AW-1:0]  o_y,
   output logic              o_busy,
   output logic              o_wrap
);

   localparam int NO = 2**AW;
   localparam int DW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
   localparam logic [AW-1:0] PTR_LAST   = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t          r_state, w_state;
   logic [AW-1:0]   r_ptr, w_ptr;
   logic [DW-1:0]   r_dwell, w_dwell;
   logic [NO-1:0]   r_y, w_y;
   logic            r_busy, w_busy;
   logic            r_wrap, w_wrap;
   logic [AW-1:0]   w_ptr_inc;

   function automatic logic [NO-1:0] onehot(input logic [AW-1:0] idx);
      logic [NO-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign w_ptr_inc = r_ptr + 1'b1;

   always_comb begin
      w_state = r_state;
      w_ptr   = r_ptr;
      w_dwell = r_dwell;
      w_y     = r_y;
      w_busy  = r_busy;
      w_wrap  = 1'b0;

      if (!i_en) begin
         w_state = ST_IDLE;
         w_ptr   = '0;
         w_dwell = '0;
         w_y     = '0;
         w_busy  = 1'b0;
      end else if (!i_mode) begin
         w_state = ST_DECODE;
         w_ptr   = '0;
         w_dwell = '0;
         w_y     = onehot(i_a);
         w_busy  = 1'b0;
      end else if (r_state != ST_SCAN) begin
         // Fresh scan entry, never a wrap even when starting at line 0.
         w_state = ST_SCAN;
         w_ptr   = i_a;
         w_dwell = '0;
         w_y     = onehot(i_a);
         w_busy  = 1'b1;
      end else if (r_dwell == DWELL_LAST) begin
         w_ptr   = w_ptr_inc;
         w_dwell = '0;
         w_y     = onehot(w_ptr_inc);
         w_wrap  = (r_ptr == PTR_LAST);
      end else begin
         w_dwell = r_dwell + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_dwell <= '0;
         r_y     <= '0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_ptr   <= w_ptr;
         r_dwell <= w_dwell;
         r_y     <= w_y;
         r_busy  <= w_busy;
         r_wrap  <= w_wrap;
      end
   end

   assign o_y    = r_y;
   assign o_busy = r_busy;
   assign o_wrap = r_wrap;

endmodule
